hsid_mse_min: RTL
=================

Name: hsid_mse_min

Overview:
- Downstream of the dual-channel MSE stage.
- Consumes the per-library-vector MSE result stream (value + reference index) for one pixel.
- Tracks the minimum MSE (best-match reference) and maximum MSE over a configured number of library vectors.
- Presents one result per pixel to the controller over a valid/ready handshake.

Parameters:
- WORD_WIDTH, 32, width of MSE values.
- HSI_LIBRARY_SIZE, 256, maximum number of library vectors per pixel.
- HSI_LIBRARY_SIZE_ADDR (localparam), $clog2(HSI_LIBRARY_SIZE), reference index width.
- CNT_WIDTH (localparam), HSI_LIBRARY_SIZE_ADDR+1, counter width, so the counter can hold HSI_LIBRARY_SIZE.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  pulse; begins a new pixel search
- library_size  input  CNT_WIDTH  number of MSE results expected; sampled on an accepted start
- mse_value  input  WORD_WIDTH  MSE result from the upstream stage
- mse_ref  input  HSI_LIBRARY_SIZE_ADDR  library vector index of mse_value
- mse_valid  input  1  mse_value/mse_ref valid; no backpressure
- min_mse_value  output  WORD_WIDTH  smallest MSE seen
- min_mse_ref  output  HSI_LIBRARY_SIZE_ADDR  index of smallest MSE
- max_mse_value  output  WORD_WIDTH  largest MSE seen
- max_mse_ref  output  HSI_LIBRARY_SIZE_ADDR  index of largest MSE
- result_valid  output  1  result fields valid; held until accepted
- result_ready  input  1  consumer accepts the result
- busy  output  1  high in RUN
- error  output  1  sticky protocol error flag

Behaviour:
- Design is one clock (clk) with asynchronous active-low reset (rst_n).
- Reset values: state IDLE, count 0, min_mse_value all-ones, min_mse_ref 0, max_mse_value 0, max_mse_ref 0, result_valid 0, busy 0, error 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and library_size in 1..HSI_LIBRARY_SIZE: latch size, count<=0, min<=all-ones/ref 0, max<=0/ref 0, error<=0, go RUN.
  - library_size > HSI_LIBRARY_SIZE: clamped to HSI_LIBRARY_SIZE.
  - library_size == 0: error<=1, stay IDLE.
- RUN, each mse_valid cycle:
  - count<=count+1.
  - mse_value < current min (strict): update min value/ref. Ties keep the earliest ref.
  - mse_value > current max (strict): update max value/ref. Ties keep the earliest ref.
  - If this is the sample that makes count == latched size: go DONE. Registered results include this sample.
- Latency: result_valid rises the cycle after the last accepted mse_valid.
- DONE:
  - result_valid=1; all result outputs stable.
  - result_ready=1: go IDLE, result_valid=0 next cycle.
  - A new start is honoured only once back in IDLE. The earliest is the cycle after the handshake.
- start in RUN: abort and restart (re-latch library_size, reset count/min/max/error). An mse_valid in the same cycle is discarded without error.
- start in DONE: ignored and error<=1. The result is not lost.
- mse_valid in IDLE or DONE: sample dropped, error<=1. Exception: start in IDLE in the same cycle drops the sample without error.
- mse_ref is not checked for ordering; it is stored as given.
- busy = (state == RUN), registered.
- error clears only on reset or an accepted start.
- Comparisons are unsigned, full WORD_WIDTH, and never saturate.

Decomposition:
- Shared package hsid_pkg holds:
  - state enum hsid_min_state_t {IDLE, RUN, DONE};
  - a typedef for the MSE word;
  - the default HSI_LIBRARY_SIZE constant, so controller and MSE stage agree.
- No sub-module needed: single module with the FSM plus two compare/update register pairs (min, max).

Test Plan:
1. start with library_size=4, then mse_valid back-to-back with (value,ref)=(50,0),(20,1),(90,2),(20,3), result_ready=1 → one cycle after the 4th sample: result_valid=1, min=20/ref1 (tie keeps earliest), max=90/ref2; IDLE next cycle.
2. library_size=3 with samples (7,5),(3,9),(8,2) and result_ready held 0 for 5 cycles → result_valid and all fields stable for 5 cycles; on ready=1, IDLE next cycle; an mse_valid during the wait sets error=1.
3. library_size=1, single sample (0xFFFFFFFF,17) → min=max=0xFFFFFFFF, both refs 17; an all-ones value still updates min_ref.
4. start with library_size=0 → stays IDLE, error=1, busy=0. Then start with size=2 → error clears, busy=1.
5. start size=4, two samples, then start size=2 plus mse_valid in the same cycle, then samples (5,0),(6,1) → result min=5/ref0, max=6/ref1, error=0.
6. Assert rst_n low mid-RUN for 1 cycle → all outputs return to reset values immediately (asynchronous); subsequent mse_valid without start sets error=1.

Source files
------------

// File: rtl/hsid_pkg.sv
// Shared definitions for the HSI pixel search pipeline (controller, MSE stage, min/max tracker).
package hsid_pkg;

  localparam int HSI_LIBRARY_SIZE_DEF = 256;
  localparam int MSE_WORD_WIDTH_DEF   = 32;

  typedef logic [MSE_WORD_WIDTH_DEF-1:0] mse_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } hsid_min_state_t;

endpackage

// File: rtl/hsid_mse_min.sv
// Tracks min/max MSE (and their reference indices) across one pixel's library sweep
// and hands the result to the controller over a valid/ready handshake.
module hsid_mse_min
  import hsid_pkg::*;
#(
  parameter  int WORD_WIDTH            = MSE_WORD_WIDTH_DEF,
  parameter  int HSI_LIBRARY_SIZE      = HSI_LIBRARY_SIZE_DEF,
  localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE),
  localparam int CNT_WIDTH             = HSI_LIBRARY_SIZE_ADDR + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             library_size,
  input  logic [WORD_WIDTH-1:0]            mse_value,
  input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_ref,
  input  logic                             mse_valid,
  output logic [WORD_WIDTH-1:0]            min_mse_value,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_mse_ref,
  output logic [WORD_WIDTH-1:0]            max_mse_value,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] max_mse_ref,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic                             busy,
  output logic                             error
);

  localparam logic [CNT_WIDTH-1:0] LIB_MAX = CNT_WIDTH'(HSI_LIBRARY_SIZE);

  hsid_min_state_t      state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, size_q;
  logic [CNT_WIDTH-1:0] size_clamped;
  logic [CNT_WIDTH-1:0] count_inc;
  logic                 size_ok;
  logic                 first;
  logic                 last;

  assign size_clamped = (library_size > LIB_MAX) ? LIB_MAX : library_size;
  assign size_ok      = (library_size != '0);
  assign count_inc    = count_q + CNT_WIDTH'(1);
  // The first sample loads both trackers so all-ones / zero values still record their ref.
  assign first        = (count_q == '0);
  assign last         = (count_inc == size_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && size_ok) state_d = RUN;
      RUN: begin
        if (start)                 state_d = size_ok ? RUN : IDLE;
        else if (mse_valid && last) state_d = DONE;
      end
      DONE: if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      size_q        <= '0;
      min_mse_value <= '1;
      min_mse_ref   <= '0;
      max_mse_value <= '0;
      max_mse_ref   <= '0;
      error         <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (start) begin
            if (size_ok) begin
              size_q        <= size_clamped;
              count_q       <= '0;
              min_mse_value <= '1;
              min_mse_ref   <= '0;
              max_mse_value <= '0;
              max_mse_ref   <= '0;
              error         <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end else if (mse_valid) begin
            if (state_q == IDLE) begin
              error <= 1'b1;
            end else begin
              count_q <= count_inc;
              if (first || (mse_value < min_mse_value)) begin
                min_mse_value <= mse_value;
                min_mse_ref   <= mse_ref;
              end
              if (first || (mse_value > max_mse_value)) begin
                max_mse_value <= mse_value;
                max_mse_ref   <= mse_ref;
              end
            end
          end
        end
        DONE: if (start || mse_valid) error <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy         = (state_q == RUN);
  assign result_valid = (state_q == DONE);

endmodule
